serializer: RTL

SERIALIZER -- requirements
Module: serializer

---
 rtl/serdes_pkg.sv | 14 +
 rtl/serializer_if.sv | 32 +++
 rtl/serdes_reg_en.sv | 29 ++
 rtl/serializer_control.sv | 99 +++++++++
 rtl/serializer.sv | 58 +++++
 5 files changed

// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared types for the serdes blocks.
//   ser_state_t : serializer control state (IDLE waits for a frame, SEND
//                 streams the buffered frame one word per handshake).
// -----------------------------------------------------------------------------
package serdes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage : serdes_pkg

// File: rtl/serializer_if.sv
// -----------------------------------------------------------------------------
// serializer_if
// Handshake bundle around the serializer.
//   recv_val / recv_rdy / recv_msg : parallel frame in (element 0 sent first)
//   send_val / send_rdy / send_msg : serial word out
// Modports:
//   slave  : the serializer itself
//   master : the environment (frame source + word sink)
// -----------------------------------------------------------------------------
interface serializer_if #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
);

  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0];
  logic                 send_val;
  logic                 send_rdy;
  logic [BIT_WIDTH-1:0] send_msg;

  modport slave (
    input  recv_val, recv_msg, send_rdy,
    output recv_rdy, send_val, send_msg
  );

  modport master (
    output recv_val, recv_msg, send_rdy,
    input  recv_rdy, send_val, send_msg
  );

endinterface : serializer_if

// File: rtl/serdes_reg_en.sv
// -----------------------------------------------------------------------------
// serdes_reg_en
// Common register cell: loads d when en is high, clears asynchronously.
//   clk   : clock
//   reset : asynchronous active-low clear
//   en    : load enable
//   d / q : data in / registered data out
// -----------------------------------------------------------------------------
module serdes_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: storage words get an explicit reset here so the idle output
  // (which shows word 0) is a defined zero rather than X after power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : serdes_reg_en

// File: rtl/serializer_control.sv
// -----------------------------------------------------------------------------
// serializer_control
// Two-state FSM plus word index for the serializer.
//   clk, reset : clock / asynchronous active-low reset
//   recv_val   : a parallel frame is offered
//   send_rdy   : downstream takes the current word
//   recv_rdy   : a frame can be accepted this cycle
//   send_val   : a serial word is being presented
//   index      : which buffered word is on send_msg
//   load_en    : frame handshake, loads the buffer
// -----------------------------------------------------------------------------
module serializer_control
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recv_val,
  input  logic                         send_rdy,
  output logic                         recv_rdy,
  output logic                         send_val,
  output logic [$clog2(N_SAMPLES)-1:0] index,
  output logic                         load_en
);

  localparam int                IDX_W    = $clog2(N_SAMPLES);
  // Compare against N_SAMPLES-1, not the counter's natural wrap, so a
  // non-power-of-two frame never addresses past the last buffer word.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  ser_state_t       state, state_next;
  logic [IDX_W-1:0] index_next;
  logic             is_last;

  assign is_last = (index == LAST_IDX);
  assign load_en = recv_val && recv_rdy;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // NOTE: every output of a combinational block is defaulted first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    index_next = index;
    unique case (state)
      IDLE: begin
        if (recv_val) begin
          state_next = SEND;
          index_next = '0;
        end
      end
      SEND: begin
        if (send_rdy) begin
          if (is_last) begin
            // Last word leaves: a new frame arriving on the same edge keeps
            // the stream going with no idle bubble.
            index_next = '0;
            state_next = recv_val ? SEND : IDLE;
          end else begin
            index_next = index + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  always_comb begin
    recv_rdy = 1'b0;
    send_val = 1'b0;
    unique case (state)
      IDLE: recv_rdy = 1'b1;
      SEND: begin
        send_val = 1'b1;
        // Buffer frees up on the very edge the last word is taken.
        recv_rdy = is_last && send_rdy;
      end
      default: begin
        recv_rdy = 1'b0;
        send_val = 1'b0;
      end
    endcase
  end

endmodule : serializer_control

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
// Accepts an N_SAMPLES-word parallel frame and streams it out one word per
// downstream handshake, element 0 first. A new frame can be accepted on the
// cycle the last word leaves, giving gap-free back-to-back frames.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   io    : serializer_if.slave (recv_* frame side, send_* word side)
// -----------------------------------------------------------------------------
module serializer #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  serializer_if.slave   io
);

  localparam int IDX_W = $clog2(N_SAMPLES);

  logic [IDX_W-1:0]     index;
  logic                 load_en;
  logic                 recv_rdy;
  logic                 send_val;
  logic [BIT_WIDTH-1:0] buffer [N_SAMPLES];

  serializer_control #(
    .N_SAMPLES (N_SAMPLES)
  ) u_control (
    .clk      (clk),
    .reset    (reset),
    .recv_val (io.recv_val),
    .send_rdy (io.send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .index    (index),
    .load_en  (load_en)
  );

  // The frame buffer only changes on a frame handshake.
  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_buf
    serdes_reg_en #(
      .WIDTH (BIT_WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (load_en),
      .d     (io.recv_msg[i]),
      .q     (buffer[i])
    );
  end

  assign io.recv_rdy = recv_rdy;
  assign io.send_val = send_val;
  // In IDLE index is 0, so this shows word 0 of the last frame (0 after reset).
  assign io.send_msg = buffer[index];

endmodule : serializer
